// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory access stage behind the EX/MEM register.
// Issues the dmem read/write handshake, stalls upstream stages until the
// memory responds, and returns aligned, sign/zero-extended load data.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses end with mem_err and issue no strobe.
//
// state | meaning
// IDLE  | no access in flight; memory instructions are detected here
// REQ   | strobe asserted, waiting for dmem_resp or for the timeout
// DONE  | result/err held for MEM/WB until advance
module mem_access_stage #(
  parameter int unsigned DMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  input  logic [3:0]  wmask_in,
  input  logic        advance,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nx;
  logic        access;
  logic        misalign;
  logic        go_req;
  logic        go_trap;
  logic        resp_hit;
  logic        tmo_hit;
  logic        tmo_fire;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  assign access = ex_valid & (mem_read | mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfword needs an even offset; word (funct3[1] set) needs offset 0.
  assign misalign = ((funct3[1:0] == 2'b01) && alu_addr[0]) ||
                    (funct3[1] && (alu_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  generate
    if (DMEM_TIMEOUT > 0) begin : g_tmo
      localparam logic [31:0] TMO_LAST = 32'(DMEM_TIMEOUT - 1);
      logic [31:0] tmo_cnt;

      // Counts REQ cycles; restarts from zero on every new request.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             tmo_cnt <= '0;
        else if (state != REQ)  tmo_cnt <= '0;
        else                    tmo_cnt <= tmo_cnt + 32'd1;
      end

      assign tmo_hit = (state == REQ) && (tmo_cnt == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // A response in the final timeout cycle still counts as a normal completion.
  assign tmo_fire = tmo_hit & ~dmem_resp;

  // Extracts the addressed byte/half and extends it according to funct3.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = rdata >> {off, 3'b000};
    half    = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  extend_load = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  extend_load = {24'h0, shifted[7:0]};
      3'b001:  extend_load = {{16{half[15]}}, half};
      3'b101:  extend_load = {16'h0, half};
      default: extend_load = rdata;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and combinational stall.
  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    go_req    = 1'b0;
    go_trap   = 1'b0;
    resp_hit  = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = access;
        if (access) begin
          if (misalign) begin
            go_trap  = 1'b1;
            state_nx = DONE;
          end else begin
            go_req   = 1'b1;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem_resp) begin
          resp_hit = 1'b1;
          state_nx = DONE;
        end else if (tmo_fire) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (advance) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_done = (state == DONE);

  // Request latch, strobe control and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      load_data        <= '0;
      mem_err          <= 1'b0;
      f3_q             <= '0;
      off_q            <= '0;
    end else if (go_req || go_trap) begin
      dmem_addr        <= {alu_addr[31:2], 2'b00};
      dmem_wdata       <= store_data << {alu_addr[1:0], 3'b000};
      dmem_byte_enable <= mem_write ? wmask_in : 4'b0000;
      f3_q             <= funct3;
      off_q            <= alu_addr[1:0];
      dmem_write       <= go_req & mem_write;
      dmem_read        <= go_req & mem_read & ~mem_write;
      load_data        <= '0;
      mem_err          <= go_trap;
    end else if (resp_hit || tmo_fire) begin
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      if (resp_hit && dmem_read) load_data <= extend_load(f3_q, off_q, dmem_rdata);
      else                       load_data <= '0;
      mem_err    <= tmo_fire;
    end else if ((state == DONE) && advance) begin
      load_data <= '0;
      mem_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a default instance (no timeout) and a
// DMEM_TIMEOUT=4 instance share the same stimulus.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, advance = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] alu_addr = '0, store_data = '0, dmem_rdata = '0;
  logic [3:0]  wmask_in = '0;
  logic        dmem_resp = 1'b0;

  logic        dmem_read, dmem_write, mem_stall, mem_done, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_byte_enable;

  logic        t_dmem_read, t_dmem_write, t_mem_stall, t_mem_done, t_mem_err;
  logic [31:0] t_dmem_addr, t_dmem_wdata, t_load_data;
  logic [3:0]  t_dmem_byte_enable;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] snap_wdata;
  logic [3:0]  snap_be;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_addr(alu_addr),
    .store_data(store_data), .wmask_in(wmask_in), .advance(advance),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .load_data(load_data),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_err(mem_err)
  );

  mem_access_stage #(.DMEM_TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_addr(alu_addr),
    .store_data(store_data), .wmask_in(wmask_in), .advance(advance),
    .dmem_read(t_dmem_read), .dmem_write(t_dmem_write), .dmem_addr(t_dmem_addr),
    .dmem_wdata(t_dmem_wdata), .dmem_byte_enable(t_dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .load_data(t_load_data),
    .mem_stall(t_mem_stall), .mem_done(t_mem_done), .mem_err(t_mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one memory op; responds in the dly-th strobe cycle; returns in DONE.
  task automatic op(input string nm, input logic r, input logic w, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] sd, input logic [3:0] m,
                    input logic [31:0] rd, input int dly, input logic [31:0] exp_addr);
    ex_valid = 1'b1; mem_read = r; mem_write = w; funct3 = f3;
    alu_addr = a; store_data = sd; wmask_in = m;
    #1;
    chk({nm, ":stall_c0"}, 32'(mem_stall), 32'd1);
    chk({nm, ":nostrobe_c0"}, 32'(dmem_read | dmem_write), 32'd0);
    for (int i = 1; i <= dly; i++) begin
      step();
      if (i == dly) begin dmem_resp = 1'b1; dmem_rdata = rd; end
      #1;
      chk({nm, ":strobe"}, 32'(w ? dmem_write : dmem_read), 32'd1);
      chk({nm, ":other_strobe"}, 32'(w ? dmem_read : dmem_write), 32'd0);
      chk({nm, ":addr"}, dmem_addr, exp_addr);
      chk({nm, ":stall_req"}, 32'(mem_stall), 32'd1);
      if (i == 1) begin snap_wdata = dmem_wdata; snap_be = dmem_byte_enable; end
    end
    step();
    dmem_resp = 1'b0;
    #1;
    chk({nm, ":done"}, 32'(mem_done), 32'd1);
    chk({nm, ":stall_done"}, 32'(mem_stall), 32'd0);
    chk({nm, ":strobes_off"}, 32'(dmem_read | dmem_write), 32'd0);
  endtask

  task automatic retire(input string nm);
    advance = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    step();
    advance = 1'b0;
    #1;
    chk({nm, ":idle_done"}, 32'(mem_done), 32'd0);
    chk({nm, ":idle_err"}, 32'(mem_err), 32'd0);
    chk({nm, ":idle_ld"}, load_data, 32'h0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst:read", 32'(dmem_read), 32'd0);
    chk("rst:write", 32'(dmem_write), 32'd0);
    chk("rst:done", 32'(mem_done), 32'd0);
    chk("rst:err", 32'(mem_err), 32'd0);
    chk("rst:addr", dmem_addr, 32'h0);
    chk("rst:wdata", dmem_wdata, 32'h0);
    chk("rst:ld", load_data, 32'h0);
    chk("rst:be", 32'(dmem_byte_enable), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Non-memory instruction passes without stall.
    ex_valid = 1'b1; #1;
    chk("alu:stall", 32'(mem_stall), 32'd0);
    step();
    chk("alu:strobe", 32'(dmem_read | dmem_write), 32'd0);
    ex_valid = 1'b0;

    op("lw", 1, 0, 3'b010, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 3, 32'h100);
    chk("lw:ld", load_data, 32'hDEADBEEF);
    chk("lw:be", 32'(snap_be), 32'h0);
    step(); #1;
    chk("lw:ld_held", load_data, 32'hDEADBEEF);
    chk("lw:done_held", 32'(mem_done), 32'd1);
    retire("lw");

    op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 4'h0, 32'h80FF7F01, 1, 32'h100);
    chk("lb:ld", load_data, 32'hFFFFFF80);
    retire("lb");
    op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 4'h0, 32'h80FF7F01, 2, 32'h100);
    chk("lbu:ld", load_data, 32'h00000080);
    retire("lbu");
    op("lb1", 1, 0, 3'b000, 32'h101, 32'h0, 4'h0, 32'h80FF7F01, 1, 32'h100);
    chk("lb1:ld", load_data, 32'h0000007F);
    retire("lb1");
    op("lh", 1, 0, 3'b001, 32'h102, 32'h0, 4'h0, 32'h80FF7F01, 1, 32'h100);
    chk("lh:ld", load_data, 32'hFFFF80FF);
    retire("lh");
    op("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 4'h0, 32'h80FF7F01, 1, 32'h100);
    chk("lhu:ld", load_data, 32'h000080FF);
    retire("lhu");
    op("lh0", 1, 0, 3'b001, 32'h100, 32'h0, 4'h0, 32'h80FF7F01, 1, 32'h100);
    chk("lh0:ld", load_data, 32'h00007F01);
    retire("lh0");

    op("sb", 0, 1, 3'b000, 32'h205, 32'h000000AB, 4'b0010, 32'hFFFFFFFF, 2, 32'h204);
    chk("sb:wdata", snap_wdata, 32'h0000AB00);
    chk("sb:be", 32'(snap_be), 32'h2);
    chk("sb:ld", load_data, 32'h0);
    retire("sb");
    // Read and write together: write wins.
    op("sh", 1, 1, 3'b001, 32'h206, 32'h0000BEEF, 4'b1100, 32'h12345678, 1, 32'h204);
    chk("sh:wdata", snap_wdata, 32'hBEEF0000);
    chk("sh:be", 32'(snap_be), 32'hC);
    chk("sh:ld", load_data, 32'h0);
    retire("sh");
    op("sw", 0, 1, 3'b010, 32'h208, 32'h12345678, 4'b1111, 32'h0, 1, 32'h208);
    chk("sw:wdata", snap_wdata, 32'h12345678);
    chk("sw:be", 32'(snap_be), 32'hF);
    retire("sw");

    // Timeout: no response ever arrives.
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_addr = 32'h300;
    #1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("tmo:strobe", 32'(t_dmem_read), 32'd1);
      chk("tmo:stall", 32'(t_mem_stall), 32'd1);
    end
    step();
    chk("tmo:strobe_off", 32'(t_dmem_read), 32'd0);
    chk("tmo:err", 32'(t_mem_err), 32'd1);
    chk("tmo:done", 32'(t_mem_done), 32'd1);
    chk("tmo:ld", t_load_data, 32'h0);
    chk("tmo0:still_req", 32'(dmem_read), 32'd1);
    chk("tmo0:no_err", 32'(mem_err), 32'd0);
    advance = 1'b1; ex_valid = 1'b0; mem_read = 1'b0;
    step();
    advance = 1'b0;
    #1;
    chk("tmo:clr_done", 32'(t_mem_done), 32'd0);
    chk("tmo:clr_err", 32'(t_mem_err), 32'd0);

    // Asynchronous reset while the default instance is stuck in REQ.
    chk("arst:pre_read", 32'(dmem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst:read", 32'(dmem_read), 32'd0);
    chk("arst:addr", dmem_addr, 32'h0);
    chk("arst:stall", 32'(mem_stall), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    dmem_resp = 1'b1; dmem_rdata = 32'h55AA55AA;
    step();
    dmem_resp = 1'b0;
    #1;
    chk("arst:done", 32'(mem_done), 32'd0);
    chk("arst:ld", load_data, 32'h0);
    chk("arst:strobe", 32'(dmem_read | dmem_write), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_addr = 32'h102;
    #1;
    chk("mis_lw:stall_c0", 32'(mem_stall), 32'd1);
    step();
    chk("mis_lw:strobe", 32'(dmem_read | dmem_write), 32'd0);
    chk("mis_lw:done", 32'(mem_done), 32'd1);
    chk("mis_lw:err", 32'(mem_err), 32'd1);
    chk("mis_lw:ld", load_data, 32'h0);
    chk("mis_lw:stall", 32'(mem_stall), 32'd0);
    retire("mis_lw");
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b001; alu_addr = 32'h103;
    step();
    chk("mis_lh:err", 32'(mem_err), 32'd1);
    chk("mis_lh:strobe", 32'(dmem_read), 32'd0);
    retire("mis_lh");
`else
    op("mis_lw", 1, 0, 3'b010, 32'h102, 32'h0, 4'h0, 32'hCAFEF00D, 1, 32'h100);
    chk("mis_lw:ld", load_data, 32'hCAFEF00D);
    chk("mis_lw:err", 32'(mem_err), 32'd0);
    retire("mis_lw");
    op("mis_lh", 1, 0, 3'b001, 32'h103, 32'h0, 4'h0, 32'h80FF7F01, 1, 32'h100);
    chk("mis_lh:ld", load_data, 32'hFFFF80FF);
    retire("mis_lh");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage that sits directly downstream of the EX/MEM pipeline register.
- Consumes the latched ALU address, store data, byte mask and load/store control.
- Runs the data-memory read/write handshake, stalls the pipeline until the memory responds, and produces aligned, sign- or zero-extended load data for the MEM/WB register.

Parameters:
- DMEM_TIMEOUT, default 0: cycles to wait for dmem_resp before forcing completion with err. 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM register holds a live instruction
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- alu_addr  in  32  effective address from EX/MEM
- store_data  in  32  rs2 value, unshifted (data in the low bytes)
- wmask_in  in  4  byte enables, already positioned for alu_addr[1:0]
- advance  in  1  downstream MEM/WB register loads this cycle
- dmem_read  out  1  memory read strobe
- dmem_write  out  1  memory write strobe
- dmem_addr  out  32  word-aligned address, {alu_addr[31:2],2'b00}
- dmem_wdata  out  32  store_data shifted left by 8*alu_addr[1:0]
- dmem_byte_enable  out  4  registered copy of wmask_in for stores, 4'b0000 for loads
- dmem_rdata  in  32  read data
- dmem_resp  in  1  single-cycle completion pulse
- load_data  out  32  extended load result, valid in DONE
- mem_stall  out  1  freeze all upstream stage registers
- mem_done  out  1  memory op result available this cycle
- mem_err  out  1  access terminated abnormally (timeout or misalign)

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE.
  - dmem_read, dmem_write, mem_done, mem_err all 0.
  - dmem_addr, dmem_wdata, load_data all 0; dmem_byte_enable=0.
  - Reset mid-transaction drops the strobes immediately. Any later dmem_resp is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - access = ex_valid & (mem_read|mem_write).
  - mem_stall = access, combinational.
  - On access: latch addr, shifted wdata, byte enable, funct3 and byte offset. Set dmem_read or dmem_write, registered. Go to REQ.
  - Non-memory instructions pass with no stall; load_data=0.
  - If mem_read and mem_write are both 1, the write has priority.
- REQ:
  - Strobes and address are held stable. mem_stall=1.
  - On dmem_resp: clear strobes, capture the extended dmem_rdata into load_data, go to DONE.
  - When DMEM_TIMEOUT>0, a counter increments each REQ cycle. On reaching DMEM_TIMEOUT with no response: clear strobes, load_data=0, mem_err=1, go to DONE.
- DONE:
  - mem_done=1 and mem_stall=0.
  - load_data and mem_err are held.
  - On advance: return to IDLE and clear mem_done and mem_err. The same-cycle ex_valid is not sampled; the new instruction is seen the next cycle in IDLE.
  - Without advance, stay in DONE.
- Latency: access detected in cycle 0; strobes high from cycle 1; resp in cycle k; DONE in cycle k+1. mem_stall is high for cycles 0..k.
- Load extension, offset o=alu_addr[1:0]:
  - lb: sext(byte[o]); lbu: zext(byte[o]).
  - lh: sext(half[o[1]]); lhu: zext(half[o[1]]).
  - lw: full word.
  - Any other funct3: word.
- dmem_resp outside REQ is ignored.
- Store: load_data=0 in DONE.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: a misaligned access is detected in IDLE. Misaligned means a halfword with o[0]=1, or a word with o!=0.
  - The block issues no strobe and goes directly IDLE->DONE.
  - mem_err=1, load_data=0; stall lasts only cycle 0.
- Undefined: misalignment is not checked. The low address bits are dropped by the word alignment and the offset still selects the lanes, wrapping within the word: for lw the data is the aligned word; for lh with o=3 the upper half is selected. mem_err is driven only by the timeout.

Test Plan:
- lw, addr 0x100, dmem_rdata=0xDEADBEEF, resp 3 cycles after strobe -> dmem_read high 3 cycles, dmem_addr=0x100, mem_stall high 4 cycles, then load_data=0xDEADBEEF, mem_done=1.
- lb at 0x103, rdata=0x80FF7F01 -> load_data=0xFFFFFF80; lbu at the same address -> 0x00000080; lh at 0x102 -> 0xFFFF80FF.
- sb, addr 0x205, store_data=0x000000AB, wmask_in=4'b0010 -> dmem_wdata=0x0000AB00, dmem_byte_enable=0010, dmem_addr=0x204, dmem_write until resp.
- DMEM_TIMEOUT=4, never respond -> strobe low after 4 REQ cycles, mem_err=1, load_data=0, mem_done=1.
- Assert rst_n=0 mid-REQ, then pulse dmem_resp after release -> strobes fall without waiting for clk, state IDLE, resp ignored, mem_done stays 0.
- MEM_MISALIGN_TRAP_EN defined, lw at 0x102 -> no strobe, mem_err=1 in the next cycle. Undefined -> dmem_addr=0x100 and the normal read completes.
